mod_n_updown_counter: RTL and testbench
=======================================

Name: mod_n_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter.
- Successor to the fixed 2-bit mod-4 ripple counter.
- All state bits are clocked by the single clk, so there are no ripple clock paths.
- Adds enable, direction, parallel load, synchronous clear, a terminal-count flag and a registered wrap pulse, for use by home-automation sequencers and timers.

Parameters:
- WIDTH, 4, counter width in bits.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 <= MODULUS <= 2**WIDTH; anything else is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- up_dn  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- clr  input  1  synchronous clear to 0.
- d_out  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- wrap  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset:
  - rst=1 forces d_out=0 and wrap=0 immediately, independent of clk.
  - Assertion mid-count aborts the current operation.
  - Counting resumes on the first rising clk edge after rst deasserts.
- Priority at each rising clk edge (rst low): clr > load > en > hold.
  - clr=1: d_out <= 0, wrap <= 0.
  - load=1: d_out <= load_val if load_val < MODULUS, else MODULUS-1 (clamped); wrap <= 0.
  - en=1, up_dn=1:
    - d_out == MODULUS-1: d_out <= 0, wrap <= 1.
    - otherwise: d_out <= d_out+1, wrap <= 0.
  - en=1, up_dn=0:
    - d_out == 0: d_out <= MODULUS-1, wrap <= 1.
    - otherwise: d_out <= d_out-1, wrap <= 0.
  - en=0 (no clr/load): d_out holds, wrap <= 0.
- tc = en & ((up_dn & d_out==MODULUS-1) | (~up_dn & d_out==0)).
  - Purely combinational; tc is not gated by clr or load.
  - During reset tc follows the same equation with d_out=0.
- Latency:
  - d_out updates 1 cycle after the qualifying edge.
  - wrap is high for exactly the 1 cycle following the wrap edge.
  - tc is high in the same cycle as the terminal value.
- Direction change (up_dn toggled) takes effect on the next enabled edge. No extra cycle is spent, and no wrap occurs unless the terminal value is crossed.
- Simultaneous events:
  - clr+load: clear wins.
  - load+en: the load value is taken and no count step occurs.
- Arithmetic: modulo MODULUS, not 2**WIDTH. d_out never leaves 0..MODULUS-1 under any input sequence.
- MODULUS == 2**WIDTH: natural binary wrap; the clamp path is never used.

Optional Feature:
- Macro MOD_N_COUNTER_SATURATE_EN.
- Defined:
  - The counter saturates: up at MODULUS-1 holds, down at 0 holds.
  - wrap is tied to 0.
  - tc behaviour is unchanged, and now signals "at limit".
- Undefined: wrap-around behaviour as specified above.
- Load, clr and reset are identical in both builds.

Test Plan:
1. Reset/async: WIDTH=4, MODULUS=10. Count to 6, then assert rst between clock edges -> d_out=0 and wrap=0 before the next edge. Deassert rst -> counting resumes 1,2,...
2. Up wrap: en=1, up_dn=1 from 0 for 12 edges -> d_out 1..9,0,1,2. tc=1 only while d_out=9. wrap=1 only in the cycle d_out=0 after 9.
3. Down wrap: load 2, then en=1, up_dn=0 -> 1,0,9,8. tc=1 at d_out=0. wrap pulses once at 9.
4. Load clamp and priority:
   - load_val=13 -> d_out=9.
   - clr=1 with load=1, load_val=5 -> d_out=0.
   - load=1, en=1, load_val=4 -> d_out=4, not 5.
5. Hold/direction: en=0 for 5 edges at d_out=7 -> stays 7, tc=0. Toggle up_dn mid-run at 3 -> sequence 3,4,3,2 with no wrap pulse.
6. Saturate build (MOD_N_COUNTER_SATURATE_EN): count up from 8 -> 9,9,9 with wrap=0 throughout and tc=1 while at 9. Count down from 1 -> 0,0 with wrap=0.

Source files
------------

// File: rtl/mod_n_updown_counter.sv
// Synchronous modulo-MODULUS up/down counter with load, clear, terminal-count flag and wrap pulse.
// Define MOD_N_COUNTER_SATURATE_EN to make the counter stop at its limits instead of wrapping.
module mod_n_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] d_out,
  output logic             tc,
  output logic             wrap
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
    $error("mod_n_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bottom;

  // Out-of-range load values pin to the top of the count range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

  assign at_top    = (cnt_q == MAX_VAL);
  assign at_bottom = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = clamp_load(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (at_top) begin
`ifdef MOD_N_COUNTER_SATURATE_EN
          cnt_d = MAX_VAL;
`else
          cnt_d  = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
      end else begin
        if (at_bottom) begin
`ifdef MOD_N_COUNTER_SATURATE_EN
          cnt_d = '0;
`else
          cnt_d  = MAX_VAL;
          wrap_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  // tc deliberately ignores clr/load: it reports the terminal state for the current direction.
  assign tc    = en & ((up_dn & at_top) | (~up_dn & at_bottom));
  assign d_out = cnt_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Scoreboard bench for mod_n_updown_counter: directed sequences followed by randomized traffic.
module tb_mod_n_updown_counter;
  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst, en, up_dn, load, clr;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] d_out;
  logic             tc, wrap;

  mod_n_updown_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .clr(clr), .d_out(d_out), .tc(tc), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wrp;
    bit tcv;
  } exp_t;

  exp_t q[$];
  int   m_cnt = 0;
  bit   m_wrap = 0;
  int   checks = 0;
  int   failures = 0;

  // Reference model: applies the inputs sampled at the last rising edge.
  task automatic model_step();
    int nxt;
    if (rst) begin
      m_cnt = 0; m_wrap = 0;
    end else if (clr) begin
      m_cnt = 0; m_wrap = 0;
    end else if (load) begin
      m_cnt  = (int'(load_val) >= MODULUS) ? MODULUS - 1 : int'(load_val);
      m_wrap = 0;
    end else if (en) begin
      nxt = m_cnt + (up_dn ? 1 : -1);
      if (nxt < 0 || nxt >= MODULUS) begin
`ifdef MOD_N_COUNTER_SATURATE_EN
        m_wrap = 0;
`else
        m_cnt  = (nxt + MODULUS) % MODULUS;
        m_wrap = 1;
`endif
      end else begin
        m_cnt  = nxt;
        m_wrap = 0;
      end
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
    exp_t x;
    @(posedge clk);
    #2;
    model_step();
    rst = r; clr = c; load = l; load_val = WIDTH'(lv); en = e; up_dn = u;
    if (r) begin
      m_cnt = 0; m_wrap = 0;
    end
    x.cnt = m_cnt;
    x.wrp = m_wrap;
    x.tcv = e && ((u && m_cnt == MODULUS - 1) || (!u && m_cnt == 0));
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      checks++;
      if (int'(d_out) != x.cnt) begin
        failures++;
        $display("FAIL d_out t=%0t got=%0d exp=%0d", $time, d_out, x.cnt);
      end
      checks++;
      if (wrap != x.wrp) begin
        failures++;
        $display("FAIL wrap t=%0t got=%0b exp=%0b", $time, wrap, x.wrp);
      end
      checks++;
      if (tc != x.tcv) begin
        failures++;
        $display("FAIL tc t=%0t got=%0b exp=%0b", $time, tc, x.tcv);
      end
    end
  end

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
    // reset, count to 6, async reset mid-cycle, resume
    repeat (2) cycle(1, 0, 0, 0, 0, 1);
    repeat (6) cycle(0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 1, 1);
    repeat (3) cycle(0, 0, 0, 0, 1, 1);
    // up wrap from 0
    cycle(0, 1, 0, 0, 0, 1);
    repeat (12) cycle(0, 0, 0, 0, 1, 1);
    // down wrap from 2
    cycle(0, 0, 1, 2, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 1, 0);
    // load clamp and priority
    cycle(0, 0, 1, 13, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 1, 1, 5, 0, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 4, 1, 1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 15, 1, 0);
    // hold at 7, then direction change at 3
    cycle(0, 0, 1, 7, 0, 1);
    repeat (5) cycle(0, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 3, 0, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3),
            ($urandom_range(0, 99) < 10), int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 80), $urandom_range(0, 1) == 1);
    end
    cycle(0, 0, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
